// File: rtl/adder_slice_sequencer.sv
// Operand stage that time-multiplexes a wide addition over one external SLICE_W-bit adder,
// LSB slice first, and rebuilds the full-width sum and carry-out from the slice results.
module adder_slice_sequencer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SLICE_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    output logic [SLICE_W-1:0] slice_a,
    output logic [SLICE_W-1:0] slice_b,
    input  logic [SLICE_W-1:0] slice_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_sum,
    output logic               out_carry,
    output logic               busy
);

    localparam int unsigned NSLICE = DATA_W / SLICE_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   sum_q, sum_d;

    logic [SLICE_W-1:0]  a_slice;
    logic [SLICE_W-1:0]  b_slice;
    logic [SLICE_W-1:0]  slice_res;
    logic                slice_carry;

    // Operand slice addressed by the current index.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < int'(NSLICE); i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_slice = a_q[i*SLICE_W +: SLICE_W];
                b_slice = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    assign slice_a = (state_q == StRun) ? a_slice : '0;
    assign slice_b = (state_q == StRun) ? b_slice : '0;

    // Carry out of slice_a + slice_b + carry: either the external add wrapped, or it produced
    // all-ones and the incoming carry pushes it over. The two cases cannot coincide.
    assign slice_res   = slice_sum + {{(SLICE_W-1){1'b0}}, carry_q};
    assign slice_carry = (slice_sum < slice_a) | (carry_q & (slice_sum == '1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int i = 0; i < int'(NSLICE); i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*SLICE_W +: SLICE_W] = slice_res;
                    end
                end
                carry_d = slice_carry;
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_sum   = sum_q;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_adder_slice_sequencer.sv
// Directed and randomised bench for adder_slice_sequencer with a behavioural 8-bit slice adder.
module tb_adder_slice_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [7:0]  slice_a;
    logic [7:0]  slice_b;
    logic [7:0]  slice_sum;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_carry;
    logic        busy;

    int checks;
    int failures;

    adder_slice_sequencer #(
        .DATA_W  (32),
        .SLICE_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .slice_a   (slice_a),
        .slice_b   (slice_b),
        .slice_sum (slice_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .busy      (busy)
    );

    // Behavioural adder_8bit
    assign slice_sum = slice_a + slice_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        #3;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=100", {in_ready, out_valid, busy});
        end
        checks++;
        if ({out_carry, out_sum, slice_a, slice_b} !== 49'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {out_carry, out_sum, slice_a, slice_b});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add_vectors;
        logic [31:0] va[3] = '{32'h0000_0001, 32'h0000_00FF, 32'hFFFF_FFFF};
        logic [31:0] vb[3] = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0001};
        logic [31:0] vs[3] = '{32'h0000_0003, 32'h0000_0100, 32'h0000_0000};
        logic        vc[3] = '{1'b0, 1'b0, 1'b1};
        int lat;
        for (int k = 0; k < 3; k++) begin
            in_a     = va[k];
            in_b     = vb[k];
            in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL vec%0d_in_ready got=%b exp=1", k, in_ready);
            end
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 20) begin
                tick();
                lat++;
            end
            checks++;
            if (lat !== 5) begin
                failures++;
                $display("FAIL vec%0d_latency got=%0d exp=5", k, lat);
            end
            checks++;
            if ({out_carry, out_sum} !== {vc[k], vs[k]}) begin
                failures++;
                $display("FAIL vec%0d_result got=%h exp=%h", k, {out_carry, out_sum},
                         {vc[k], vs[k]});
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                failures++;
                $display("FAIL vec%0d_release got=%b exp=01", k, {out_valid, in_ready});
            end
        end
    endtask

    task automatic test_slice_trace;
        logic [7:0] ea[4] = '{8'h01, 8'h7F, 8'hFF, 8'h80};
        logic [7:0] eb[4] = '{8'hFF, 8'h80, 8'hFF, 8'h80};
        in_a     = 32'h80FF_7F01;
        in_b     = 32'h80FF_80FF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({slice_a, slice_b, busy, in_ready} !== {ea[k], eb[k], 2'b10}) begin
                failures++;
                $display("FAIL trace_slice%0d got=%h/%h busy=%b rdy=%b exp=%h/%h busy=1 rdy=0",
                         k, slice_a, slice_b, busy, in_ready, ea[k], eb[k]);
            end
            tick();
        end
        checks++;
        if ({out_valid, out_carry, out_sum, slice_a, slice_b} !== {2'b11, 32'h01FF_0000, 16'h0})
        begin
            failures++;
            $display("FAIL trace_result got=v%b c%b %h sl=%h/%h exp=v1 c1 01ff0000 sl=00/00",
                     out_valid, out_carry, out_sum, slice_a, slice_b);
        end
        // Leave result pending for the stall test
    endtask

    task automatic test_stall;
        int bad = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_a     = 32'h1111_0000 + k;
            in_b     = 32'h2222_0000;
            tick();
            if ({out_valid, in_ready, busy, out_carry, out_sum} !== {4'b1011, 32'h01FF_0000})
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL stall_hold got=%0d_bad_cycles exp=0", bad);
        end
        // in_valid still high at the handshake edge: must not be taken this cycle
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, busy, in_ready, out_carry, out_sum} !== {4'b0011, 32'h01FF_0000}) begin
            failures++;
            $display("FAIL stall_release got=v%b b%b r%b %b_%h exp=v0 b0 r1 1_01ff0000",
                     out_valid, busy, in_ready, out_carry, out_sum);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if ({busy, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL stall_no_accept got=%b exp=01", {busy, in_ready});
        end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        int lat;
        in_a     = 32'h1234_5678;
        in_b     = 32'h0101_0101;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({slice_a, slice_b} !== 16'h3401) begin
            failures++;
            $display("FAIL midrst_idx2 got=%h exp=3401", {slice_a, slice_b});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, out_carry, out_sum, slice_a, slice_b}
            !== {3'b100, 49'h0}) begin
            failures++;
            $display("FAIL midrst_outputs got=%b_%h exp=100_0",
                     {in_ready, out_valid, busy}, {out_carry, out_sum, slice_a, slice_b});
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL midrst_no_stale got=%0d_bad_cycles exp=0", bad);
        end
        in_a     = 32'd5;
        in_b     = 32'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if ({lat, out_carry, out_sum} !== {32'd5, 1'b0, 32'd12}) begin
            failures++;
            $display("FAIL midrst_next got=lat%0d %b_%h exp=lat5 0_0000000c",
                     lat, out_carry, out_sum);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int acc_cyc[2];
        int n_acc = 0;
        int n_res = 0;
        logic [32:0] res[2];
        logic acc;
        out_ready = 1'b1;
        in_a      = 32'h0000_0001;
        in_b      = 32'h0000_0001;
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            acc = in_valid & in_ready;
            if (out_valid === 1'b1 && n_res < 2) begin
                res[n_res] = {out_carry, out_sum};
                n_res++;
            end
            tick();
            if (acc === 1'b1 && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    in_a = 32'hFFFF_FFFF;
                    in_b = 32'h0000_0003;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        checks++;
        if (n_acc !== 2 || n_res !== 2) begin
            failures++;
            $display("FAIL b2b_counts got=acc%0d res%0d exp=acc2 res2", n_acc, n_res);
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] !== 6) begin
                failures++;
                $display("FAIL b2b_interval got=%0d exp=6", acc_cyc[1] - acc_cyc[0]);
            end
            checks++;
            if (res[0] !== 33'h0_0000_0002 || res[1] !== 33'h1_0000_0002) begin
                failures++;
                $display("FAIL b2b_results got=%h,%h exp=000000002,100000002", res[0], res[1]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] exp;
        int lat;
        for (int n = 0; n < 2000; n++) begin
            in_valid  = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) tick();
            a        = $urandom;
            b        = $urandom;
            exp      = {1'b0, a} + {1'b0, b};
            in_a     = a;
            in_b     = b;
            in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL rnd%0d_in_ready got=%b exp=1", n, in_ready);
            end
            tick();
            lat = 1;
            while (out_valid !== 1'b1 && lat < 20) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_a      = $urandom;
                in_b      = $urandom;
                out_ready = 1'($urandom_range(0, 1));
                tick();
                lat++;
            end
            checks++;
            if ({lat, out_carry, out_sum} !== {32'd5, exp}) begin
                failures++;
                $display("FAIL rnd%0d_result got=lat%0d %h exp=lat5 %h a=%h b=%h",
                         n, lat, {out_carry, out_sum}, exp, a, b);
            end
            out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            out_ready = 1'b1;
            tick();
            in_valid  = 1'b0;
            out_ready = 1'b0;
            checks++;
            if ({out_valid, in_ready, out_carry, out_sum} !== {2'b01, exp}) begin
                failures++;
                $display("FAIL rnd%0d_release got=%b_%h exp=01_%h", n,
                         {out_valid, in_ready}, {out_carry, out_sum}, exp);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add_vectors();
        test_slice_trace();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
